// File: rtl/cnu_msg_gen.sv
// Offset min-sum check-node message generator: takes one (min, min2, min_idx, sgn)
// frame and streams D check-to-variable messages {sign, magnitude}, one per edge.
module cnu_msg_gen #(
    parameter int data_w = 8,
    parameter int idx_w  = 8,
    parameter int D      = 5,
    parameter int OFFSET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [data_w-1:0] min,
    input  logic [data_w-1:0] min2,
    input  logic [idx_w-1:0]  min_idx,
    input  logic [D-1:0]      sgn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [data_w:0]   out_msg,
    output logic [idx_w-1:0]  out_idx,
    output logic              out_last
);

    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [data_w-1:0] OFF  = data_w'(OFFSET);
    localparam logic [idx_w-1:0]  LAST = idx_w'(D - 1);

    state_t             state;
    logic [idx_w-1:0]   k;
    logic [data_w-1:0]  min_r;
    logic [data_w-1:0]  min2_r;
    logic [idx_w-1:0]   idx_r;
    logic [D-1:0]       sgn_r;
    logic               par_r;
    logic               accept;
    logic               fire;
    logic [idx_w-1:0]   k_next;

    // Message for edge kk; sign is suppressed on a zero magnitude.
    function automatic logic [data_w:0] beat_msg(
        input logic [data_w-1:0] m,
        input logic [data_w-1:0] m2,
        input logic [idx_w-1:0]  mi,
        input logic [idx_w-1:0]  kk,
        input logic [D-1:0]      s,
        input logic              p
    );
        logic [data_w-1:0] raw;
        logic [data_w-1:0] mag;
        logic              sb;
        raw = (kk == mi) ? m2 : m;
        mag = (raw > OFF) ? raw - OFF : '0;
        sb  = 1'b0;
        for (int unsigned i = 0; i < D; i++) begin
            if (idx_w'(i) == kk) sb = s[i];
        end
        return {(mag != '0) && (p ^ sb), mag};
    endfunction

    assign fire     = out_valid && out_ready;
    assign in_ready = (state == IDLE) || (fire && out_last);
    assign accept   = in_valid && in_ready;
    assign k_next   = k + 1'b1;

    // Beat 0 is computed straight from the inputs so a new frame needs no extra cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            min_r     <= '0;
            min2_r    <= '0;
            idx_r     <= '0;
            sgn_r     <= '0;
            par_r     <= 1'b0;
            out_valid <= 1'b0;
            out_msg   <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else if (accept) begin
            state     <= EMIT;
            k         <= '0;
            min_r     <= min;
            min2_r    <= min2;
            idx_r     <= min_idx;
            sgn_r     <= sgn;
            par_r     <= ^sgn;
            out_valid <= 1'b1;
            out_msg   <= beat_msg(min, min2, min_idx, '0, sgn, ^sgn);
            out_idx   <= '0;
            out_last  <= (LAST == '0);
        end else if (fire) begin
            if (out_last) begin
                state     <= IDLE;
                k         <= '0;
                out_valid <= 1'b0;
            end else begin
                k         <= k_next;
                out_msg   <= beat_msg(min_r, min2_r, idx_r, k_next, sgn_r, par_r);
                out_idx   <= k_next;
                out_last  <= (k_next == LAST);
            end
        end
    end

endmodule

// File: tb/tb_cnu_msg_gen.sv
// Bench for cnu_msg_gen: vector table, directed handshake corner cases and
// randomized traffic against a per-frame reference model scoreboard.
module tb_cnu_msg_gen;

    localparam int DW = 8;
    localparam int IW = 8;
    localparam int DD = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] min;
    logic [DW-1:0] min2;
    logic [IW-1:0] min_idx;
    logic [DD-1:0] sgn;
    logic          out_valid;
    logic          out_ready;
    logic [DW:0]   out_msg;
    logic [IW-1:0] out_idx;
    logic          out_last;

    int tests  = 0;
    int errors = 0;

    cnu_msg_gen #(.data_w(DW), .idx_w(IW), .D(DD), .OFFSET(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .min(min), .min2(min2), .min_idx(min_idx), .sgn(sgn),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_msg(out_msg), .out_idx(out_idx), .out_last(out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish (act=running req=finished)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: act=0x%0h req=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct packed {
        logic [DW:0]   msg;
        logic [IW-1:0] idx;
        logic          last;
    } beat_t;

    beat_t sbq[$];

    function automatic void model_push(input int m, input int m2, input int mi, input logic [DD-1:0] s);
        int    p;
        beat_t b;
        p = $countones(s) % 2;
        for (int k = 0; k < DD; k++) begin
            int raw;
            int mag;
            int sign;
            raw  = (k == mi) ? m2 : m;
            mag  = raw - 1;
            if (mag < 0) mag = 0;
            sign = (mag == 0) ? 0 : (p ^ int'(s[k]));
            b.msg  = 9'(sign * 256 + mag);
            b.idx  = 8'(k);
            b.last = (k == DD - 1);
            sbq.push_back(b);
        end
    endfunction

    logic          prev_stall = 1'b0;
    logic [DW:0]   prev_msg;
    logic [IW-1:0] prev_idx;
    logic          prev_last;

    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {out_valid, out_last, out_idx, out_msg},
                      {1'b1, prev_last, prev_idx, prev_msg});
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check("sb_unexpected_beat", {out_idx, out_msg}, 32'hFFFF_FFFF);
                end else begin
                    beat_t e;
                    e = sbq.pop_front();
                    check("sb_beat", {out_last, out_idx, out_msg}, {e.last, e.idx, e.msg});
                end
            end
            if (in_valid && in_ready)
                model_push(int'(min), int'(min2), int'(min_idx), sgn);
            prev_stall = out_valid && !out_ready;
            prev_msg   = out_msg;
            prev_idx   = out_idx;
            prev_last  = out_last;
        end
    end

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [DW-1:0]      m;
        logic [DW-1:0]      m2;
        logic [IW-1:0]      mi;
        logic [DD-1:0]      s;
        logic [DD-1:0][DW:0] exp;
    } vec_t;

    vec_t vecs[4];

    task automatic send(input logic [DW-1:0] m, input logic [DW-1:0] m2,
                        input logic [IW-1:0] mi, input logic [DD-1:0] s);
        bit acc;
        acc = 1'b0;
        min = m; min2 = m2; min_idx = mi; sgn = s; in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        check("send_accepted", 32'(acc), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        min = '0; min2 = '0; min_idx = '0; sgn = '0;

        vecs[0] = '{m: 8'd3,  m2: 8'd7,  mi: 8'd2, s: 5'b00101,
                    exp: {9'h002, 9'h002, 9'h106, 9'h002, 9'h102}};
        vecs[1] = '{m: 8'd1,  m2: 8'd0,  mi: 8'd0, s: 5'b00001,
                    exp: {9'h000, 9'h000, 9'h000, 9'h000, 9'h000}};
        vecs[2] = '{m: 8'd4,  m2: 8'd9,  mi: 8'd5, s: 5'b00000,
                    exp: {9'h003, 9'h003, 9'h003, 9'h003, 9'h003}};
        vecs[3] = '{m: 8'd10, m2: 8'd20, mi: 8'd4, s: 5'b11010,
                    exp: {9'h013, 9'h009, 9'h109, 9'h009, 9'h109}};

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_msg",   32'(out_msg),   32'd0);
        check("rst_out_idx",   32'(out_idx),   32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // table-driven frames
        out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            send(vecs[v].m, vecs[v].m2, vecs[v].mi, vecs[v].s);
            for (int k = 0; k < DD; k++) begin
                @(negedge clk);
                check("vec_valid", 32'(out_valid), 32'd1);
                check("vec_msg",   32'(out_msg),   32'(vecs[v].exp[k]));
                check("vec_idx",   32'(out_idx),   32'(k));
                check("vec_last",  32'(out_last),  32'(k == DD - 1));
                @(posedge clk); #1;
            end
            @(negedge clk);
            check("vec_idle_after", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end

        // backpressure on beat 1
        send(8'd3, 8'd7, 8'd2, 5'b00101);
        @(negedge clk);
        check("bp_beat0", 32'(out_idx), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_hold", {out_valid, out_idx, out_msg}, {1'b1, 8'd1, 9'h002});
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_beat1", {out_valid, out_idx}, {1'b1, 8'd1});
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_beat2", {out_valid, out_idx, out_msg}, {1'b1, 8'd2, 9'h106});
        repeat (4) @(posedge clk);
        #1;

        // back-to-back frames with no bubble
        min = 8'd5; min2 = 8'd6; min_idx = 8'd1; sgn = 5'b10011; in_valid = 1'b1;
        @(negedge clk);
        check("b2b_first_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        min = 8'd2; min2 = 8'd40; min_idx = 8'd3; sgn = 5'b01000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("b2b_valid", {out_valid, out_idx}, {1'b1, 8'(i % DD)});
            if (i < DD) check("b2b_in_ready", 32'(in_ready), 32'(i == DD - 1));
            @(posedge clk); #1;
            if (i == DD - 1) in_valid = 1'b0;
        end
        @(negedge clk);
        check("b2b_end_idle", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // reset at beat 2
        send(8'd8, 8'd12, 8'd0, 5'b11111);
        begin
            bit seen;
            seen = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (out_valid && out_idx == 8'd2) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("rst_mid_reach_beat2", 32'(seen), 32'd1);
        end
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_valid_drop", {out_valid, out_msg}, 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_after", {in_ready, out_valid, out_idx}, {1'b1, 1'b0, 8'd0});
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_mid_no_partial", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bit acc;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(3) != 0);
                min      = ($urandom_range(3) == 0) ? 8'($urandom_range(2)) : 8'($urandom_range(255));
                min2     = 8'($urandom_range(255));
                min_idx  = 8'($urandom_range(DD));
                sgn      = 5'($urandom_range(31));
            end
            out_ready = ($urandom_range(3) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !out_valid) break;
        end
        check("drain_empty", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/cnu_msg_gen.md
CNU_MSG_GEN -- requirements
Module: cnu_msg_gen

Interface
REQ-001 Parameter data_w, 8, magnitude width of min/min2 and of the output magnitude.
REQ-002 Parameter idx_w, 8, width of min_idx and out_idx.
REQ-003 Parameter D, 5, check-node degree (edges per frame), D >= 2.
REQ-004 Parameter OFFSET, 1, offset min-sum correction subtracted from each magnitude.
REQ-005 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1, reset, asynchronous and active-high.
REQ-007 Port in_valid, input, 1, a new frame (min, min2, min_idx, sgn) is presented.
REQ-008 Port in_ready, output, 1, the block accepts a frame this cycle.
REQ-009 Port min, input, data_w, smallest incoming magnitude (comparison-tree output).
REQ-010 Port min2, input, data_w, second-smallest incoming magnitude.
REQ-011 Port min_idx, input, idx_w, edge index of min; the value D (odd-D padding slot) matches no edge.
REQ-012 Port sgn, input, D, sign bit of each incoming variable-to-check message; bit k belongs to edge k.
REQ-013 Port out_valid, output, 1, out_msg/out_idx/out_last are valid.
REQ-014 Port out_ready, input, 1, downstream accepts the current beat.
REQ-015 Port out_msg, output, data_w+1, check-to-variable message as {sign, magnitude}.
REQ-016 Port out_idx, output, idx_w, edge index k of the current beat.
REQ-017 Port out_last, output, 1, high when out_idx == D-1.

Function
REQ-018 The block SHALL implement two states: IDLE (no frame held) and EMIT (frame held, beats pending).
REQ-019 A frame SHALL be accepted on a cycle where in_valid && in_ready; accepting registers min, min2, min_idx and sgn, and computes parity P = XOR of all D sgn bits.
REQ-020 in_ready SHALL be asserted combinationally when state == IDLE, or when out_valid && out_ready && out_last.
REQ-021 On acceptance, the block SHALL enter EMIT with beat counter k = 0 and assert out_valid starting the next cycle, giving a latency of 1 cycle from acceptance to the first beat.
REQ-022 For beat k, the raw magnitude SHALL be min2 when k == min_idx, and min otherwise.
REQ-023 The output magnitude SHALL be raw minus OFFSET, saturated at 0 (no wrap-around).
REQ-024 The output sign SHALL be P XOR sgn[k]; when the output magnitude is 0, the sign SHALL be forced to 0 (no negative zero).
REQ-025 out_msg, out_idx and out_last SHALL be driven from registers and SHALL stay stable while out_valid && !out_ready.
REQ-026 k SHALL advance only on out_valid && out_ready; on acceptance of beat D-1 the state SHALL return to IDLE, unless a new frame is accepted in the same cycle.
REQ-027 If a new frame is accepted in the same cycle as beat D-1, the next cycle SHALL present beat 0 of the new frame with out_valid held high (no bubble).
REQ-028 in_valid SHALL be ignored while in EMIT except on the last-beat handshake cycle; the held frame SHALL never be overwritten mid-emission.
REQ-029 The counter width SHALL be idx_w, and k SHALL never exceed D-1.

Reset
REQ-030 While rst is high, the block SHALL force state = IDLE, k = 0, out_valid = 0, out_msg = 0, out_idx = 0, out_last = 0, and all frame registers to 0, asynchronously.
REQ-031 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL be in IDLE with in_ready = 1, and no partial beats SHALL be emitted.

Verification
REQ-032 Basic frame (D=5, OFFSET=1): min=3, min2=7, min_idx=2, sgn=5'b00101 -> beats k0..k4 are out_msg = {1,2}, {0,2}, {1,6}, {0,2}, {0,2}, with out_last only on k4.
REQ-033 Saturation and negative zero: min=1, min2=0, min_idx=0, sgn=5'b00001 -> beat 0 = {0,0}; beats 1..4 have magnitude 0 with sign 0.
REQ-034 Padding index: min_idx=5, min=4, min2=9, sgn=0 -> all five beats = {0,3}; min2 is never used.
REQ-035 Backpressure: hold out_ready low for 3 cycles on beat 1 -> out_msg/out_idx are unchanged throughout, in_ready = 0, and beat 2 follows one cycle after out_ready rises.
REQ-036 Back-to-back: in_valid is held high with a second frame, out_ready = 1 -> the second frame is accepted on the k4 handshake, its beat 0 appears the next cycle, and the stream shows 10 consecutive valid beats.
REQ-037 Reset at beat 2 -> out_valid drops immediately, and after release in_ready = 1 and out_idx = 0.
